// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I load-use/load-to-branch hazard controller with PC select and perf counters
// Stall FSM inserts LOAD_LAT bubbles per load hazard; redirects under bus stall are parked until the bus frees.
module hazard_ctrl #(
    parameter int                XLEN     = 32,
    parameter int                RA_W     = 5,
    parameter int                LOAD_LAT = 1,
    parameter int                CNT_W    = 16,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        id_opcode_i,
    input  logic [6:0]        ex_opcode_i,
    input  logic [6:0]        ma_opcode_i,
    input  logic              ex_reg_we_i,
    input  logic              ma_reg_we_i,
    input  logic [RA_W-1:0]   id_rs1_i,
    input  logic [RA_W-1:0]   id_rs2_i,
    input  logic [RA_W-1:0]   ex_rd_i,
    input  logic [RA_W-1:0]   ma_rd_i,
    input  logic              ex_redirect_i,
    input  logic [XLEN-1:0]   ex_target_i,
    input  logic              m_axi_stall_i,
    input  logic [XLEN-1:0]   pc4_i,
    output logic [XLEN-1:0]   pc_o,
    output logic              if_stall_o,
    output logic              id_stall_o,
    output logic              id_flush_o,
    output logic              ex_flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [3:0] LAT_M1     = 4'(LOAD_LAT - 1);

    typedef enum logic [1:0] {RUN, LSTALL, RPEND} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   tgt_q, tgt_d;
    logic [XLEN-1:0]   pc_hold_q, pc_hold_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic rs1_used, rs2_used, ex_match, ma_match, hz_ex, hz_ma, load_hz;
    logic [XLEN-1:0] pc_int;
    logic if_stall_int, id_stall_int, id_flush_int, ex_flush_int;

    always_comb begin
        rs1_used = !(id_opcode_i inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        rs2_used = id_opcode_i inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        ex_match = (ex_rd_i != '0) &&
                   ((rs1_used && id_rs1_i == ex_rd_i) || (rs2_used && id_rs2_i == ex_rd_i));
        ma_match = (ma_rd_i != '0) &&
                   ((rs1_used && id_rs1_i == ma_rd_i) || (rs2_used && id_rs2_i == ma_rd_i));
        hz_ex    = (ex_opcode_i == OPC_LOAD) && ex_reg_we_i && ex_match;
        // A branch compares in EX, so a load still in MA is too late for it
        hz_ma    = (ma_opcode_i == OPC_LOAD) && ma_reg_we_i &&
                   (id_opcode_i == OPC_BRANCH) && ma_match;
        load_hz  = hz_ex || hz_ma;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tgt_d        = tgt_q;
        pc_int       = pc4_i;
        if_stall_int = 1'b0;
        id_stall_int = 1'b0;
        id_flush_int = 1'b0;
        ex_flush_int = 1'b0;
        if (m_axi_stall_i) begin
            if_stall_int = 1'b1;
            id_stall_int = 1'b1;
            pc_int       = pc_hold_q;
            if (ex_redirect_i) begin
                tgt_d   = ex_target_i;
                cnt_d   = '0;
                state_d = RPEND;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (ex_redirect_i) begin
                        pc_int       = ex_target_i;
                        id_flush_int = 1'b1;
                        ex_flush_int = 1'b1;
                    end else if (load_hz) begin
                        if_stall_int = 1'b1;
                        id_stall_int = 1'b1;
                        ex_flush_int = 1'b1;
                        pc_int       = pc_hold_q;
                        if (LOAD_LAT > 1) begin
                            cnt_d   = LAT_M1;
                            state_d = LSTALL;
                        end
                    end
                end
                LSTALL: begin
                    if (ex_redirect_i) begin
                        pc_int       = ex_target_i;
                        id_flush_int = 1'b1;
                        ex_flush_int = 1'b1;
                        cnt_d        = '0;
                        state_d      = RUN;
                    end else begin
                        if_stall_int = 1'b1;
                        id_stall_int = 1'b1;
                        ex_flush_int = 1'b1;
                        pc_int       = pc_hold_q;
                        cnt_d        = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) state_d = RUN;
                    end
                end
                RPEND: begin
                    pc_int       = tgt_q;
                    id_flush_int = 1'b1;
                    ex_flush_int = 1'b1;
                    state_d      = RUN;
                end
                default: state_d = RUN;
            endcase
        end
        pc_hold_d = m_axi_stall_i ? pc_hold_q : pc_int;
    end

    // Outputs are forced quiet while reset is held, independent of flop state
    assign pc_o        = rst_n ? pc_int : RESET_PC;
    assign if_stall_o  = rst_n && if_stall_int;
    assign id_stall_o  = rst_n && id_stall_int;
    assign id_flush_o  = rst_n && id_flush_int;
    assign ex_flush_o  = rst_n && ex_flush_int;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (id_stall_o && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (id_flush_o && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            tgt_q       <= '0;
            pc_hold_q   <= RESET_PC;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tgt_q       <= tgt_d;
            pc_hold_q   <= pc_hold_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
// Two instances (LOAD_LAT 3 / 16-bit counters and LOAD_LAT 1 / 4-bit counters) share stimulus.
module tb_hazard_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0080;
    localparam logic [6:0] LOAD = 7'b0000011, OP = 7'b0110011, STORE = 7'b0100011,
                           BRANCH = 7'b1100011, LUI = 7'b0110111, AUIPC = 7'b0010111,
                           JAL = 7'b1101111, OPIMM = 7'b0010011, JALR = 7'b1100111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [6:0]  id_op, ex_op, ma_op;
    logic        ex_we, ma_we;
    logic [4:0]  id_rs1, id_rs2, ex_rd, ma_rd;
    logic        redir, bus;
    logic [31:0] target, pc4;

    logic [31:0] pc0, pc1;
    logic        ifs0, ids0, idf0, exf0, ifs1, ids1, idf1, exf1;
    logic [15:0] scnt0, fcnt0;
    logic [3:0]  scnt1, fcnt1;

    hazard_ctrl #(.XLEN(32), .RA_W(5), .LOAD_LAT(3), .CNT_W(16), .RESET_PC(RPC)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_opcode_i(id_op), .ex_opcode_i(ex_op), .ma_opcode_i(ma_op),
        .ex_reg_we_i(ex_we), .ma_reg_we_i(ma_we), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_rd_i(ex_rd), .ma_rd_i(ma_rd), .ex_redirect_i(redir), .ex_target_i(target),
        .m_axi_stall_i(bus), .pc4_i(pc4), .pc_o(pc0), .if_stall_o(ifs0), .id_stall_o(ids0),
        .id_flush_o(idf0), .ex_flush_o(exf0), .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0));

    hazard_ctrl #(.XLEN(32), .RA_W(5), .LOAD_LAT(1), .CNT_W(4), .RESET_PC(RPC)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_opcode_i(id_op), .ex_opcode_i(ex_op), .ma_opcode_i(ma_op),
        .ex_reg_we_i(ex_we), .ma_reg_we_i(ma_we), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .ex_rd_i(ex_rd), .ma_rd_i(ma_rd), .ex_redirect_i(redir), .ex_target_i(target),
        .m_axi_stall_i(bus), .pc4_i(pc4), .pc_o(pc1), .if_stall_o(ifs1), .id_stall_o(ids1),
        .id_flush_o(idf1), .ex_flush_o(exf1), .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1));

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: bubbles still owed, parked redirect, held PC, event tallies
    int          lat[2]  = '{3, 1};
    int          cmax[2] = '{65535, 15};
    int          bub[2], scnt[2], fcnt[2], n_bub[2], n_scnt[2], n_fcnt[2];
    bit          pend[2], n_pend[2];
    logic [31:0] ptgt[2], hold[2], n_ptgt[2], n_hold[2];
    logic [31:0] e_pc[2];
    bit          e_ifs[2], e_ids[2], e_idf[2], e_exf[2];

    function automatic bit hazard();
        bit r1, r2, me, mm;
        r1 = !(id_op == LUI || id_op == AUIPC || id_op == JAL);
        r2 = (id_op == OP || id_op == STORE || id_op == BRANCH);
        me = ex_rd != 0 && ((r1 && id_rs1 == ex_rd) || (r2 && id_rs2 == ex_rd));
        mm = ma_rd != 0 && ((r1 && id_rs1 == ma_rd) || (r2 && id_rs2 == ma_rd));
        return (ex_op == LOAD && ex_we && me) || (ma_op == LOAD && ma_we && id_op == BRANCH && mm);
    endfunction

    task automatic model_eval();
        for (int i = 0; i < 2; i++) begin
            e_ifs[i] = 0; e_ids[i] = 0; e_idf[i] = 0; e_exf[i] = 0;
            n_bub[i] = bub[i]; n_pend[i] = pend[i]; n_ptgt[i] = ptgt[i]; n_hold[i] = hold[i];
            if (!rst_n) begin
                e_pc[i] = RPC;
                n_bub[i] = 0; n_pend[i] = 0; n_ptgt[i] = 0; n_hold[i] = RPC;
                n_scnt[i] = 0; n_fcnt[i] = 0;
            end else begin
                if (bus) begin
                    e_ifs[i] = 1; e_ids[i] = 1; e_pc[i] = hold[i];
                    if (redir) begin n_pend[i] = 1; n_ptgt[i] = target; n_bub[i] = 0; end
                end else if (pend[i]) begin
                    e_pc[i] = ptgt[i]; e_idf[i] = 1; e_exf[i] = 1; n_pend[i] = 0;
                end else if (redir) begin
                    e_pc[i] = target; e_idf[i] = 1; e_exf[i] = 1; n_bub[i] = 0;
                end else if (bub[i] > 0 || hazard()) begin
                    e_ifs[i] = 1; e_ids[i] = 1; e_exf[i] = 1; e_pc[i] = hold[i];
                    n_bub[i] = (bub[i] > 0) ? bub[i] - 1 : lat[i] - 1;
                end else begin
                    e_pc[i] = pc4;
                end
                if (!bus) n_hold[i] = e_pc[i];
                n_scnt[i] = (scnt[i] + int'(e_ids[i]) > cmax[i]) ? cmax[i] : scnt[i] + int'(e_ids[i]);
                n_fcnt[i] = (fcnt[i] + int'(e_idf[i]) > cmax[i]) ? cmax[i] : fcnt[i] + int'(e_idf[i]);
            end
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
        chk("dut0 pc_o", pc0, e_pc[0]);       chk("dut1 pc_o", pc1, e_pc[1]);
        chk("dut0 if_stall", {31'b0, ifs0}, {31'b0, e_ifs[0]});
        chk("dut1 if_stall", {31'b0, ifs1}, {31'b0, e_ifs[1]});
        chk("dut0 id_stall", {31'b0, ids0}, {31'b0, e_ids[0]});
        chk("dut1 id_stall", {31'b0, ids1}, {31'b0, e_ids[1]});
        chk("dut0 id_flush", {31'b0, idf0}, {31'b0, e_idf[0]});
        chk("dut1 id_flush", {31'b0, idf1}, {31'b0, e_idf[1]});
        chk("dut0 ex_flush", {31'b0, exf0}, {31'b0, e_exf[0]});
        chk("dut1 ex_flush", {31'b0, exf1}, {31'b0, e_exf[1]});
    endtask

    task automatic clk_adv();
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            bub[i] = n_bub[i]; pend[i] = n_pend[i]; ptgt[i] = n_ptgt[i]; hold[i] = n_hold[i];
            scnt[i] = n_scnt[i]; fcnt[i] = n_fcnt[i];
        end
        chk("dut0 stall_cnt", {16'b0, scnt0}, scnt[0]);  chk("dut1 stall_cnt", {28'b0, scnt1}, scnt[1]);
        chk("dut0 flush_cnt", {16'b0, fcnt0}, fcnt[0]);  chk("dut1 flush_cnt", {28'b0, fcnt1}, fcnt[1]);
    endtask

    task automatic step();
        settle();
        clk_adv();
    endtask

    task automatic idle();
        id_op = OPIMM; ex_op = OPIMM; ma_op = OPIMM; ex_we = 0; ma_we = 0;
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ma_rd = 0; redir = 0; bus = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; idle(); step(); rst_n = 1;
    endtask

    typedef struct {
        logic [6:0] idop; logic [4:0] rs1, rs2;
        logic [6:0] exop; logic exwe; logic [4:0] exrd;
        logic [6:0] maop; logic mawe; logic [4:0] mard;
        logic rd; logic e_stall, e_idf, e_exf;
    } vec_t;
    vec_t tbl[11];

    int n_bubbles, n_held, n_flush;
    logic [6:0] pool[9];

    initial begin
        tbl[0]  = '{OP,     1, 2, LOAD, 1, 1, OPIMM, 0, 0, 0, 1, 0, 1};
        tbl[1]  = '{OP,     0, 0, LOAD, 1, 0, OPIMM, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{LUI,    1, 1, LOAD, 1, 1, OPIMM, 0, 0, 0, 0, 0, 0};
        tbl[3]  = '{BRANCH, 5, 6, OP,   1, 9, LOAD,  1, 5, 0, 1, 0, 1};
        tbl[4]  = '{OP,     5, 0, OP,   1, 9, LOAD,  1, 5, 0, 0, 0, 0};
        tbl[5]  = '{STORE,  2, 1, LOAD, 1, 1, OPIMM, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{OPIMM,  3, 1, LOAD, 1, 1, OPIMM, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{OP,     1, 2, LOAD, 0, 1, OPIMM, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{OP,     1, 2, LOAD, 1, 1, OPIMM, 0, 0, 1, 0, 1, 1};
        tbl[9]  = '{JAL,    1, 1, LOAD, 1, 1, OPIMM, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{OP,     1, 2, OP,   1, 1, OPIMM, 0, 0, 0, 0, 0, 0};
        pool = '{LOAD, OP, STORE, BRANCH, LUI, AUIPC, JAL, OPIMM, JALR};
        for (int i = 0; i < 2; i++) begin
            bub[i] = 0; pend[i] = 0; ptgt[i] = 0; hold[i] = RPC; scnt[i] = 0; fcnt[i] = 0;
        end
        pc4 = 32'h0000_2004; target = 32'h0000_3000;
        do_reset();

        foreach (tbl[k]) begin
            do_reset();
            id_op = tbl[k].idop; id_rs1 = tbl[k].rs1; id_rs2 = tbl[k].rs2;
            ex_op = tbl[k].exop; ex_we = tbl[k].exwe; ex_rd = tbl[k].exrd;
            ma_op = tbl[k].maop; ma_we = tbl[k].mawe; ma_rd = tbl[k].mard; redir = tbl[k].rd;
            #1;
            chk($sformatf("vec%0d id_stall", k), {31'b0, ids1}, {31'b0, tbl[k].e_stall});
            chk($sformatf("vec%0d id_flush", k), {31'b0, idf1}, {31'b0, tbl[k].e_idf});
            chk($sformatf("vec%0d ex_flush", k), {31'b0, exf1}, {31'b0, tbl[k].e_exf});
            chk($sformatf("vec%0d pc_o", k), pc1,
                tbl[k].rd ? 32'h3000 : (tbl[k].e_stall ? RPC : 32'h2004));
            step();
        end

        // LOAD_LAT=3 hazard with a bus stall in the second bubble
        do_reset();
        pc4 = 32'h500; n_bubbles = 0; n_held = 0;
        id_op = OP; id_rs1 = 1; id_rs2 = 2; ex_op = LOAD; ex_we = 1; ex_rd = 1;
        for (int c = 0; c < 4; c++) begin
            settle();
            if (exf0) n_bubbles++;
            if (pc0 == RPC) n_held++;
            clk_adv();
            ex_op = OPIMM; ex_rd = 0;
            bus = (c == 1);
        end
        settle();
        chk("lat3 after ex_flush", {31'b0, exf0}, 32'd0);
        chk("lat3 after pc_o", pc0, 32'h500);
        clk_adv();
        chk("lat3 bubble count", n_bubbles, 32'd3);
        chk("lat3 pc held cycles", n_held, 32'd4);
        chk("lat3 stall_cnt", {16'b0, scnt0}, 32'd4);

        // Redirect during LSTALL
        do_reset();
        id_op = OP; id_rs1 = 1; id_rs2 = 2; ex_op = LOAD; ex_we = 1; ex_rd = 1;
        step();
        ex_op = OPIMM; ex_rd = 0; redir = 1; target = 32'h100;
        settle();
        chk("lstall redir pc_o", pc0, 32'h100);
        chk("lstall redir flushes", {30'b0, idf0, exf0}, 32'd3);
        chk("lstall redir id_stall", {31'b0, ids0}, 32'd0);
        clk_adv();
        chk("lstall redir flush_cnt", {16'b0, fcnt0}, 32'd1);
        redir = 0; pc4 = 32'h600;
        settle();
        chk("lstall redir back to run", {31'b0, ids0}, 32'd0);
        clk_adv();

        // Redirect parked under a four-cycle bus stall
        do_reset();
        target = 32'h200; pc4 = 32'h700; n_flush = 0;
        for (int c = 0; c < 4; c++) begin
            redir = (c == 0); bus = 1;
            settle();
            if (idf0 || exf0) n_flush++;
            clk_adv();
        end
        chk("rpend no flush while stalled", n_flush, 32'd0);
        redir = 0; bus = 0; target = 32'h0;
        settle();
        chk("rpend pc_o", pc0, 32'h200);
        chk("rpend flushes", {30'b0, idf0, exf0}, 32'd3);
        clk_adv();
        settle();
        chk("rpend single pulse", {31'b0, idf0}, 32'd0);
        clk_adv();
        chk("rpend flush_cnt", {16'b0, fcnt0}, 32'd1);

        // Reset while parked discards the redirect
        do_reset();
        target = 32'h200; redir = 1; bus = 1;
        step();
        redir = 0;
        step();
        rst_n = 0;
        settle();
        chk("rpend reset pc_o", pc0, RPC);
        chk("rpend reset stall", {31'b0, ids0}, 32'd0);
        clk_adv();
        rst_n = 1; bus = 0;
        settle();
        chk("rpend reset no flush", {31'b0, idf0}, 32'd0);
        chk("rpend reset pc_o after", pc0, 32'h700);
        clk_adv();

        // Counter saturation on the 4-bit instance
        do_reset();
        bus = 1;
        repeat (20) step();
        chk("sat stall_cnt dut1", {28'b0, scnt1}, 32'd15);
        chk("sat stall_cnt dut0", {16'b0, scnt0}, 32'd20);
        bus = 0;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst_n  = ($urandom % 100) != 0;
            id_op  = pool[$urandom % 9]; ex_op = pool[$urandom % 9]; ma_op = pool[$urandom % 9];
            if ($urandom % 3 == 0) ex_op = LOAD;
            if ($urandom % 3 == 0) ma_op = LOAD;
            ex_we  = $urandom % 4 != 0;  ma_we = $urandom % 4 != 0;
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); ma_rd  = 5'($urandom_range(0, 3));
            bus    = ($urandom % 5) == 0;
            redir  = ($urandom % 8) == 0;
            target = $urandom; pc4 = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
